// File: rtl/hazard_scheduler.sv
// Issue-side register scoreboard plus round-robin arbiter sharing the single
// register-file write port between the ALU (wb0) and memory (wb1) writeback paths.
module hazard_scheduler #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_src1,
    input  logic [AW-1:0]   iss_src2,
    input  logic [AW-1:0]   iss_dest,
    input  logic            iss_wr,
    output logic            iss_ready,
    input  logic            wb0_valid,
    input  logic [AW-1:0]   wb0_reg,
    input  logic [DW-1:0]   wb0_val,
    input  logic            wb1_valid,
    input  logic [AW-1:0]   wb1_reg,
    input  logic [DW-1:0]   wb1_val,
    output logic            wb0_ready,
    output logic            wb1_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy_mask,
    output logic            wb_err,
    output logic [15:0]     stall_cnt
);
    logic [NREG-1:0] pend, pendNext;
    logic            lastGrant;   // 1: wb1 won most recently, so wb0 is favoured next
    logic            issFire, wbFire, errNext;
    logic [AW-1:0]   wbReg;
    logic [DW-1:0]   wbVal;

    // No bypass: a register freed this edge becomes readable only next cycle.
    assign iss_ready = !pend[iss_src1] && !pend[iss_src2] && (!iss_wr || !pend[iss_dest]);
    assign issFire   = iss_valid && iss_ready;

    assign wb0_ready = wb0_valid && (!wb1_valid || lastGrant);
    assign wb1_ready = wb1_valid && (!wb0_valid || !lastGrant);
    assign wbFire    = wb0_ready || wb1_ready;
    assign wbReg     = wb1_ready ? wb1_reg : wb0_reg;
    assign wbVal     = wb1_ready ? wb1_val : wb0_val;
    assign busy_mask = pend;

    always_comb begin
        pendNext = pend;
        if (rf_we)
            pendNext[rf_waddr] = 1'b0;
        if (issFire && iss_wr)
            pendNext[iss_dest] = 1'b1;
    end

    // Orphan writebacks, and a new claim landing on a register mid-clear, both mark corruption.
    assign errNext = (wbFire && !pend[wbReg]) ||
                     (issFire && iss_wr && rf_we && (iss_dest == rf_waddr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            lastGrant <= 1'b1;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            wb_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pend  <= pendNext;
            rf_we <= wbFire;
            if (wbFire) begin
                lastGrant <= wb1_ready;
                rf_waddr  <= wbReg;
                rf_wdata  <= wbVal;
            end
            if (errNext)
                wb_err <= 1'b1;
            if (iss_valid && !iss_ready && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
